// File: rtl/mux4_rr_arbiter_pkg.sv
// Shared definitions for the round-robin mux arbiter: FSM encoding, requester count
// and the rotating-priority pick used both from IDLE and on owner release.
package arb_pkg;

    typedef enum logic {
        IDLE  = 1'b0,
        GRANT = 1'b1
    } state_t;

    localparam int REQ_W = 4;

    typedef struct packed {
        logic       found;
        logic [1:0] idx;
    } pick_t;

    // Scan last+1, last+2, ... (mod 4); the final step wraps back onto last itself.
    function automatic pick_t rr_pick(input logic [REQ_W-1:0] req, input logic [1:0] last);
        pick_t      p;
        logic [1:0] idx;
        p = '0;
        for (int k = 1; k <= REQ_W; k++) begin
            idx = last + 2'(k);
            if (!p.found && req[idx]) begin
                p.found = 1'b1;
                p.idx   = idx;
            end
        end
        return p;
    endfunction

    function automatic logic [REQ_W-1:0] onehot4(input logic [1:0] idx);
        return 4'b0001 << idx;
    endfunction

endpackage

// File: rtl/mux4_rr_arbiter_mux.sv
// Plain combinational N-bit 4:1 multiplexer; s selects a1..a4 as 0..3.
module mux4x1_nbit #(
    parameter int N = 4
) (
    input  logic [N-1:0] a1,
    input  logic [N-1:0] a2,
    input  logic [N-1:0] a3,
    input  logic [N-1:0] a4,
    input  logic [1:0]   s,
    output logic [N-1:0] f
);

    always_comb begin
        f = a1;
        case (s)
            2'd0: f = a1;
            2'd1: f = a2;
            2'd2: f = a3;
            2'd3: f = a4;
            default: f = a1;
        endcase
    end

endmodule

// File: rtl/mux4_rr_arbiter.sv
// Round-robin owner of a shared 4:1 mux: one-hot grant, burst-limited ownership,
// registered output word tagged with the requester that produced it.
module mux4_rr_arbiter
    import arb_pkg::*;
#(
    parameter int N         = 4,
    parameter int MAX_BURST = 8
) (
    input  logic         clk,
    input  logic         rst_n,
    input  logic [3:0]   req,
    input  logic [N-1:0] d0,
    input  logic [N-1:0] d1,
    input  logic [N-1:0] d2,
    input  logic [N-1:0] d3,
    output logic [3:0]   gnt,
    output logic [1:0]   sel,
    output logic [N-1:0] dout,
    output logic         dout_valid,
    output logic [1:0]   dout_src
);

    localparam int              CNT_W    = $clog2(MAX_BURST + 1);
    localparam logic [CNT_W-1:0] CNT_LAST = CNT_W'(MAX_BURST - 1);

    state_t           state;
    logic [CNT_W-1:0] cnt;
    logic [1:0]       last;
    logic [N-1:0]     mux_f;
    logic             xfer;
    logic             release_now;
    pick_t            pick_idle;
    pick_t            pick_owner;

    mux4x1_nbit #(.N(N)) u_mux (
        .a1(d0),
        .a2(d1),
        .a3(d2),
        .a4(d3),
        .s (sel),
        .f (mux_f)
    );

    // Handshake: the owner transfers in every cycle it holds req while granted;
    // dout_valid is high for exactly one cycle per transferred word, with no backpressure.
    assign xfer        = (state == GRANT) && gnt[sel] && req[sel];
    assign release_now = (state == GRANT) && (!req[sel] || (xfer && cnt == CNT_LAST));
    assign pick_idle   = rr_pick(req, last);
    assign pick_owner  = rr_pick(req, sel);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state      <= IDLE;
            gnt        <= '0;
            sel        <= '0;
            cnt        <= '0;
            last       <= 2'd3;
            dout       <= '0;
            dout_valid <= 1'b0;
            dout_src   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    dout_valid <= 1'b0;
                    if (pick_idle.found) begin
                        gnt   <= onehot4(pick_idle.idx);
                        sel   <= pick_idle.idx;
                        cnt   <= '0;
                        state <= GRANT;
                    end
                end
                GRANT: begin
                    if (xfer) begin
                        dout       <= mux_f;
                        dout_src   <= sel;
                        dout_valid <= 1'b1;
                        cnt        <= cnt + 1'b1;
                    end else begin
                        dout_valid <= 1'b0;
                    end
                    if (release_now) begin
                        last <= sel;
                        cnt  <= '0;
                        // A lone owner at its burst limit passes through IDLE, so its
                        // re-grant shows a one-cycle gap instead of an endless burst.
                        if (pick_owner.found && pick_owner.idx != sel) begin
                            gnt <= onehot4(pick_owner.idx);
                            sel <= pick_owner.idx;
                        end else begin
                            gnt   <= '0;
                            state <= IDLE;
                        end
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mux4_rr_arbiter.sv
// Bench for mux4_rr_arbiter: directed scenarios then random request traffic,
// checked against a queue-based reference of grants and transferred words.
module tb_mux4_rr_arbiter;

    localparam int N  = 4;
    localparam int MB = 8;

    logic         clk = 1'b0;
    logic         rst_n;
    logic [3:0]   req;
    logic [N-1:0] d [4];
    logic [3:0]   gnt;
    logic [1:0]   sel;
    logic [N-1:0] dout;
    logic         dout_valid;
    logic [1:0]   dout_src;

    int checks = 0;
    int errors = 0;

    logic [N+1:0] exp_q[$];

    int m_owner;
    int m_cnt;
    int m_last;
    int m_sel;

    mux4_rr_arbiter #(.N(N), .MAX_BURST(MB)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .req       (req),
        .d0        (d[0]),
        .d1        (d[1]),
        .d2        (d[2]),
        .d3        (d[3]),
        .gnt       (gnt),
        .sel       (sel),
        .dout      (dout),
        .dout_valid(dout_valid),
        .dout_src  (dout_src)
    );

    // clock / reset
    always #5 clk = ~clk;

    function automatic void chk(input string name, input logic [7:0] act, input logic [7:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h at %0t", name, act, exp, $time);
        end
    endfunction

    function automatic int ref_pick(input logic [3:0] r, input int from);
        for (int k = 1; k <= 4; k++) begin
            if (r[(from + k) % 4]) return (from + k) % 4;
        end
        return -1;
    endfunction

    // reference model: who owns the mux this cycle, and which word it moves
    function automatic void model_step(input logic [3:0] r);
        int o;
        int w;
        if (m_owner < 0) begin
            w = ref_pick(r, m_last);
            if (w >= 0) begin
                m_owner = w;
                m_sel   = w;
                m_cnt   = 0;
            end
        end else begin
            o = m_owner;
            if (r[o]) begin
                exp_q.push_back({2'(o), d[o]});
                m_cnt++;
            end
            if (!r[o] || m_cnt == MB) begin
                m_last = o;
                m_cnt  = 0;
                w = ref_pick(r, o);
                if (w >= 0 && w != o) begin
                    m_owner = w;
                    m_sel   = w;
                end else begin
                    m_owner = -1;
                end
            end
        end
    endfunction

    // driver tasks
    task automatic cycle(input logic [3:0] r);
        logic [7:0] eg;
        req = r;
        for (int i = 0; i < 4; i++) d[i] = N'($urandom);
        @(negedge clk);
        eg = (m_owner < 0) ? 8'd0 : 8'(1 << m_owner);
        chk("gnt", {4'd0, gnt}, eg);
        chk("sel", {6'd0, sel}, 8'(m_sel));
        model_step(r);
        @(posedge clk);
        #1;
    endtask

    task automatic do_reset(input logic [3:0] r);
        req   = r;
        rst_n = 1'b0;
        #1;
        chk("rst_gnt", {4'd0, gnt}, 8'd0);
        chk("rst_sel", {6'd0, sel}, 8'd0);
        chk("rst_dout", 8'(dout), 8'd0);
        chk("rst_dout_valid", {7'd0, dout_valid}, 8'd0);
        chk("rst_dout_src", {6'd0, dout_src}, 8'd0);
        exp_q.delete();
        m_owner = -1;
        m_cnt   = 0;
        m_last  = 3;
        m_sel   = 0;
        repeat (2) @(posedge clk);
        #1;
        rst_n = 1'b1;
    endtask

    // scoreboard monitor
    always @(negedge clk) begin
        logic [N+1:0] e;
        if (rst_n === 1'b1 && dout_valid === 1'b1) begin
            if (exp_q.size() == 0) begin
                chk("dout_unexpected", {7'd0, dout_valid}, 8'd0);
            end else begin
                e = exp_q.pop_front();
                chk("dout", 8'(dout), 8'(e[N-1:0]));
                chk("dout_src", {6'd0, dout_src}, 8'(e[N+1:N]));
            end
        end
    end

    initial begin
        logic [3:0] r;
        int         rst_at;
        req = '0;
        for (int i = 0; i < 4; i++) d[i] = '0;
        do_reset(4'hF);

        // requester 0 wins first after reset
        repeat (3) cycle(4'hF);
        do_reset(4'hF);

        // single requester, three words, then drop back to idle
        repeat (4) cycle(4'b0100);
        repeat (3) cycle(4'b0000);

        // all requesting: rotation with no gap between owners
        repeat (40) cycle(4'b1111);
        repeat (2) cycle(4'b0000);

        // lone owner hits the burst limit and is re-granted after a gap
        repeat (22) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        // owner 3 drops while requester 1 waits
        repeat (3) cycle(4'b1000);
        repeat (3) cycle(4'b0010);
        repeat (2) cycle(4'b0000);

        // reset in the middle of a burst
        repeat (5) cycle(4'b0100);
        do_reset(4'b0100);
        repeat (4) cycle(4'b0101);
        repeat (2) cycle(4'b0000);

        // random traffic with sticky requests and one random reset
        r      = 4'($urandom);
        rst_at = $urandom_range(500, 2500);
        for (int i = 0; i < 3000; i++) begin
            for (int b = 0; b < 4; b++) begin
                if ($urandom_range(0, 7) == 0) r[b] = ~r[b];
            end
            if (i == rst_at) do_reset(r);
            cycle(r);
        end

        repeat (4) cycle(4'b0000);
        chk("queue_drained", 8'(exp_q.size()), 8'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
